cache_writeback_engine: RTL and testbench

//  Reads one cache line (index, chan) out of the cache data memory and sends it to main

---
 rtl/cache_pkg.sv | 25 ++
 rtl/line_serializer.sv | 37 +++
 rtl/cache_writeback_engine.sv | 130 +++++++++++++
 tb/tb_cache_writeback_engine.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache types and sizing helpers for the writeback path.
// Optional feature macro used by cache_writeback_engine: WB_PARITY_EN.
package cache_pkg;

  typedef enum logic [1:0] {WB_IDLE, WB_READ, WB_SEND, WB_DONE} wb_state_t;

  // Number of bus beats needed to move one cache line.
  function automatic int calc_beats(input int line_w, input int bus_w);
    return line_w / bus_w;
  endfunction

  // Beat counter width; a single-beat line still needs a 1-bit counter.
  function automatic int calc_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Memory line address is {tag, index}.
  function automatic int mem_addr_w(input int tag_w, input int idx_w);
    return tag_w + idx_w;
  endfunction

  localparam int BEATS          = calc_beats(64, 16);
  localparam int BEAT_CNT_WIDTH = calc_cnt_w(BEATS);

endpackage

// File: rtl/line_serializer.sv
// Holds one cache line and presents it one bus beat at a time, low beat first.
module line_serializer #(
  parameter int BUS_W  = 16,
  parameter int NBEATS = 4,
  parameter int CNT_W  = 2
) (
  input  logic                    clk,
  input  logic                    not_reset,
  input  logic                    i_load,
  input  logic [NBEATS*BUS_W-1:0] i_line,
  input  logic                    i_advance,
  output logic [BUS_W-1:0]        o_data,
  output logic                    o_last
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  logic [NBEATS-1:0][BUS_W-1:0] r_line;
  logic [CNT_W-1:0]             r_beat;

  // Parallel load restarts at beat 0; each accepted beat steps, wrapping after the last.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      r_line <= '0;
      r_beat <= '0;
    end else if (i_load) begin
      r_line <= i_line;
      r_beat <= '0;
    end else if (i_advance) begin
      r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
    end
  end

  assign o_data = r_line[r_beat];
  assign o_last = (r_beat == LAST_BEAT);

endmodule

// File: rtl/cache_writeback_engine.sv
// Writeback engine: reads one victim line from the data memory and bursts it
// to main memory over valid/ready, then pulses done.
// Define WB_PARITY_EN to add the even-parity output o_mem_parity.
module cache_writeback_engine
  import cache_pkg::*;
#(
  parameter int AINDEX_WIDTH   = 8,
  parameter int CH_NUM_WIDTH   = 2,
  parameter int CASH_STR_WIDTH = 64,
  parameter int TAG_WIDTH      = 22,
  parameter int MEM_BUS_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 not_reset,
  input  logic                                 i_req_valid,
  output logic                                 o_req_ready,
  input  logic [AINDEX_WIDTH-1:0]              i_req_index,
  input  logic [CH_NUM_WIDTH-1:0]              i_req_chan,
  input  logic [TAG_WIDTH-1:0]                 i_req_tag,
  output logic [AINDEX_WIDTH-1:0]              o_dm_index,
  output logic [CH_NUM_WIDTH-1:0]              o_dm_chan,
  input  logic [CASH_STR_WIDTH-1:0]            i_dm_data,
  output logic                                 o_mem_valid,
  input  logic                                 i_mem_ready,
  output logic [TAG_WIDTH+AINDEX_WIDTH-1:0]    o_mem_addr,
  output logic [MEM_BUS_WIDTH-1:0]             o_mem_data,
  output logic                                 o_mem_last,
`ifdef WB_PARITY_EN
  output logic                                 o_mem_parity,
`endif
  output logic                                 o_done
);

  localparam int NBEATS = calc_beats(CASH_STR_WIDTH, MEM_BUS_WIDTH);
  localparam int CNT_W  = calc_cnt_w(NBEATS);
  localparam int MAW    = mem_addr_w(TAG_WIDTH, AINDEX_WIDTH);

  wb_state_t                 r_state;
  logic                      r_req_ready;
  logic                      r_mem_valid;
  logic                      r_done;
  logic [AINDEX_WIDTH-1:0]   r_dm_index;
  logic [CH_NUM_WIDTH-1:0]   r_dm_chan;
  logic [MAW-1:0]            r_mem_addr;

  logic                      w_load;
  logic                      w_accept;
  logic [MEM_BUS_WIDTH-1:0]  w_data;
  logic                      w_last;

  // Line is captured during the single READ cycle, when dm_index/dm_chan are already driven.
  assign w_load   = (r_state == WB_READ);
  assign w_accept = r_mem_valid & i_mem_ready;

  line_serializer #(
    .BUS_W  (MEM_BUS_WIDTH),
    .NBEATS (NBEATS),
    .CNT_W  (CNT_W)
  ) u_ser (
    .clk       (clk),
    .not_reset (not_reset),
    .i_load    (w_load),
    .i_line    (i_dm_data),
    .i_advance (w_accept),
    .o_data    (w_data),
    .o_last    (w_last)
  );

  // Control FSM with registered handshake outputs; request fields latch only in IDLE.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      r_state     <= WB_IDLE;
      r_req_ready <= 1'b1;
      r_mem_valid <= 1'b0;
      r_done      <= 1'b0;
      r_dm_index  <= '0;
      r_dm_chan   <= '0;
      r_mem_addr  <= '0;
    end else begin
      case (r_state)
        WB_IDLE: begin
          if (i_req_valid) begin
            r_dm_index  <= i_req_index;
            r_dm_chan   <= i_req_chan;
            r_mem_addr  <= {i_req_tag, i_req_index};
            r_req_ready <= 1'b0;
            r_state     <= WB_READ;
          end
        end
        WB_READ: begin
          r_mem_valid <= 1'b1;
          r_state     <= WB_SEND;
        end
        WB_SEND: begin
          if (w_accept && w_last) begin
            r_mem_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= WB_DONE;
          end
        end
        WB_DONE: begin
          r_done      <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= WB_IDLE;
        end
        default: begin
          r_mem_valid <= 1'b0;
          r_done      <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= WB_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_mem_valid = r_mem_valid;
  assign o_done      = r_done;
  assign o_dm_index  = r_dm_index;
  assign o_dm_chan   = r_dm_chan;
  assign o_mem_addr  = r_mem_addr;
  // Beat data and last flag are only meaningful with valid; keep them quiet otherwise.
  assign o_mem_data  = r_mem_valid ? w_data : '0;
  assign o_mem_last  = r_mem_valid & w_last;

`ifdef WB_PARITY_EN
  assign o_mem_parity = ^o_mem_data;
`endif

endmodule

// File: tb/tb_cache_writeback_engine.sv
// Scoreboard bench for cache_writeback_engine: directed scenarios plus random traffic.
module tb_cache_writeback_engine;

  localparam int AW  = 8;
  localparam int CW  = 2;
  localparam int LW  = 64;
  localparam int TW  = 22;
  localparam int BW  = 16;
  localparam int NB  = LW / BW;
  localparam int MAW = TW + AW;

  logic           clk = 1'b0;
  logic           not_reset = 1'b0;
  logic           i_req_valid = 1'b0;
  logic           o_req_ready;
  logic [AW-1:0]  i_req_index = '0;
  logic [CW-1:0]  i_req_chan = '0;
  logic [TW-1:0]  i_req_tag = '0;
  logic [AW-1:0]  o_dm_index;
  logic [CW-1:0]  o_dm_chan;
  logic [LW-1:0]  i_dm_data;
  logic           o_mem_valid;
  logic           i_mem_ready = 1'b0;
  logic [MAW-1:0] o_mem_addr;
  logic [BW-1:0]  o_mem_data;
  logic           o_mem_last;
`ifdef WB_PARITY_EN
  logic           o_mem_parity;
`endif
  logic           o_done;

  always #5 clk = ~clk;

  cache_writeback_engine dut (
    .clk          (clk),
    .not_reset    (not_reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_index  (i_req_index),
    .i_req_chan   (i_req_chan),
    .i_req_tag    (i_req_tag),
    .o_dm_index   (o_dm_index),
    .o_dm_chan    (o_dm_chan),
    .i_dm_data    (i_dm_data),
    .o_mem_valid  (o_mem_valid),
    .i_mem_ready  (i_mem_ready),
    .o_mem_addr   (o_mem_addr),
    .o_mem_data   (o_mem_data),
    .o_mem_last   (o_mem_last),
`ifdef WB_PARITY_EN
    .o_mem_parity (o_mem_parity),
`endif
    .o_done       (o_done)
  );

  // Behavioural data memory: combinational read at the engine's requested slot.
  logic [LW-1:0] dmem [0:(1<<(AW+CW))-1];
  always_comb i_dm_data = dmem[{o_dm_chan, o_dm_index}];

  typedef struct {
    logic [MAW-1:0] addr;
    logic [BW-1:0]  data;
    logic           last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    done_due = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: push the model's burst on request acceptance, pop and compare on every beat handshake.
  always @(negedge clk) begin
    if (!not_reset) begin
      exp_q.delete();
      done_due = 1'b0;
    end else begin
      if (o_done || done_due) check("done_pulse", 64'(o_done), 64'(done_due));
      done_due = 1'b0;
      if (o_mem_valid) check("ready_low_in_burst", 64'(o_req_ready), 64'd0);
      if (o_mem_valid && i_mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h expected no beat", o_mem_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", 64'(o_mem_data), 64'(e.data));
          check("beat_addr", 64'(o_mem_addr), 64'(e.addr));
          check("beat_last", 64'(o_mem_last), 64'(e.last));
`ifdef WB_PARITY_EN
          check("beat_parity", 64'(o_mem_parity), 64'(^e.data));
`endif
          if (e.last) done_due = 1'b1;
        end
      end
      if (i_req_valid && o_req_ready) begin
        logic [LW-1:0] line;
        line = dmem[{i_req_chan, i_req_index}];
        for (int k = 0; k < NB; k++) begin
          beat_t b;
          b.addr = {i_req_tag, i_req_index};
          b.data = BW'(line >> (k * BW));
          b.last = (k == NB - 1);
          exp_q.push_back(b);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      step();
      if (o_done) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  task automatic issue(input logic [AW-1:0] idx, input logic [CW-1:0] ch, input logic [TW-1:0] tag);
    i_req_index = idx;
    i_req_chan  = ch;
    i_req_tag   = tag;
    i_req_valid = 1'b1;
  endtask

  logic [63:0] t1;

  initial begin
    for (int i = 0; i < (1 << (AW + CW)); i++) dmem[i] = {$urandom, $urandom};
    t1 = 64'hDDDD_CCCC_BBBB_AAAA;
    dmem[{2'd2, 8'h05}] = t1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(o_req_ready), 64'd1);
    check("rst_mem_valid", 64'(o_mem_valid), 64'd0);
    check("rst_done",      64'(o_done),      64'd0);
    check("rst_dm_index",  64'(o_dm_index),  64'd0);
    check("rst_mem_addr",  64'(o_mem_addr),  64'd0);
    check("rst_mem_data",  64'(o_mem_data),  64'd0);
    check("rst_mem_last",  64'(o_mem_last),  64'd0);
    not_reset = 1'b1;
    step();

    // 1: nominal burst with exact latency
    i_mem_ready = 1'b1;
    issue(8'h05, 2'd2, 22'h1234);
    step();
    i_req_valid = 1'b0;
    check("t1_dm_index", 64'(o_dm_index), 64'h05);
    check("t1_dm_chan",  64'(o_dm_chan),  64'd2);
    check("t1_read_valid", 64'(o_mem_valid), 64'd0);
    for (int k = 0; k < NB; k++) begin
      step();
      check("t1_valid", 64'(o_mem_valid), 64'd1);
      check("t1_data",  64'(o_mem_data),  64'(t1[k*BW +: BW]));
      check("t1_last",  64'(o_mem_last),  64'(k == NB - 1));
      check("t1_addr",  64'(o_mem_addr),  64'({22'h1234, 8'h05}));
    end
    step();
    check("t1_done",      64'(o_done),      64'd1);
    check("t1_done_valid", 64'(o_mem_valid), 64'd0);
    check("t1_done_ready", 64'(o_req_ready), 64'd0);
    step();
    check("t1_ready_back", 64'(o_req_ready), 64'd1);
    check("t1_done_gone",  64'(o_done),      64'd0);

    // 2: stall on beat 1
    issue(8'h05, 2'd2, 22'h1234);
    step();
    i_req_valid = 1'b0;
    step();
    step();
    i_mem_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("t2_stall_data",  64'(o_mem_data),  64'hBBBB);
      check("t2_stall_valid", 64'(o_mem_valid), 64'd1);
      step();
    end
    i_mem_ready = 1'b1;
    check("t2_post_stall_data", 64'(o_mem_data), 64'hBBBB);
    wait_done("t2_done", 20);
    step();
    check("t2_single_done", 64'(o_done), 64'd0);

    // 3: request held through the burst; second one taken only after done
    issue(8'h11, 2'd1, 22'h0ABCD);
    step();
    i_req_index = 8'h22;
    i_req_tag   = 22'h3_0F0F;
    for (int j = 0; j < 3; j++) begin
      step();
      check("t3_ready_busy", 64'(o_req_ready), 64'd0);
    end
    wait_done("t3_done_a", 20);
    step();
    check("t3_ready_after_done", 64'(o_req_ready), 64'd1);
    step();
    i_req_valid = 1'b0;
    check("t3_second_index", 64'(o_dm_index), 64'h22);
    wait_done("t3_done_b", 20);
    step();

    // 4: reset mid-burst
    issue(8'h05, 2'd2, 22'h1234);
    step();
    i_req_valid = 1'b0;
    step();
    step();
    step();
    not_reset = 1'b0;
    #1;
    check("t4_valid_abort", 64'(o_mem_valid), 64'd0);
    check("t4_ready_abort", 64'(o_req_ready), 64'd1);
    for (int j = 0; j < 2; j++) begin
      step();
      check("t4_no_done", 64'(o_done), 64'd0);
    end
    not_reset = 1'b1;
    step();
    issue(8'h05, 2'd2, 22'h1234);
    step();
    i_req_valid = 1'b0;
    step();
    check("t4_restart_beat0", 64'(o_mem_data), 64'hAAAA);
    wait_done("t4_done", 20);
    step();

    // 5: parity on known beats
`ifdef WB_PARITY_EN
    dmem[{2'd0, 8'h07}] = 64'h0000_0000_0003_0007;
    issue(8'h07, 2'd0, 22'h1);
    step();
    i_req_valid = 1'b0;
    step();
    check("t5_parity_0007", 64'(o_mem_parity), 64'd1);
    step();
    check("t5_parity_0003", 64'(o_mem_parity), 64'd0);
    wait_done("t5_done", 20);
    step();
`endif

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      i_mem_ready = ($urandom_range(0, 3) != 0);
      i_req_valid = ($urandom_range(0, 2) == 0);
      i_req_index = AW'($urandom);
      i_req_chan  = CW'($urandom);
      i_req_tag   = TW'($urandom);
      step();
    end
    i_req_valid = 1'b0;
    i_mem_ready = 1'b1;
    for (int c = 0; c < 100 && (exp_q.size() != 0 || !o_req_ready || done_due); c++) step();
    step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_idle",  64'(o_req_ready),  64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
